alu_seq_arbiter: RTL and testbench
==================================

// Module: alu_seq_arbiter
//
// PURPOSE
// - Shares the 8-bit ALU and its bus-drive enable between two requesters.
// - Round-robin arbitration picks one requester, then sequences the operation:
//   load reg A, load reg B, execute, drive result onto the shared bus.
// - Sits beside the ALU; its outputs drive the register load strobes, the ALU sel and the ALU bus enable.
//
// PARAMETERS
// WIDTH   8   data width of the reg_B observation port; matches the ALU
//
// PORTS
// clk      in   1      system clock, rising edge
// rst      in   1      asynchronous, active-high reset
// req_0    in   1      requester 0 wants an ALU operation; level, held until done
// op_0     in   2      requester 0 opcode: 00 ADD, 01 SUB, 10 MLT, 11 DIV
// req_1    in   1      requester 1 request; same rules as req_0
// op_1     in   2      requester 1 opcode
// reg_b    in   WIDTH  current register B contents; used only for the divide-by-zero check
// gnt_0    out  1      requester 0 owns the bus/ALU; high from LD_A through OUT
// gnt_1    out  1      requester 1 owns the bus/ALU
// load_a   out  1      strobe: register A captures the bus this cycle
// load_b   out  1      strobe: register B captures the bus this cycle
// alu_sel  out  2      ALU operation select, from the latched opcode
// alu_en   out  1      ALU drives its result onto the bus
// done     out  1      one-cycle pulse in the final cycle of a transaction
// err      out  1      one-cycle pulse with done on an aborted DIV by zero (macro only)
// busy     out  1      high in every state except IDLE
//
// BEHAVIOUR
// - Reset (async, any time): state=IDLE, all outputs 0, alu_sel=00, rr_last=1 (req_0 wins first tie).
// - Reset mid-transaction aborts immediately; no done pulse.
// - FSM (all registered, one state per cycle):
//   - IDLE: if any req: grant per round-robin, latch that op, go LD_A; else stay.
//   - LD_A: gnt_x=1, load_a=1; requester drives operand A on bus -> LD_B.
//   - LD_B: gnt_x=1, load_b=1; requester drives operand B -> EXEC.
//   - EXEC: gnt_x=1; ALU registers result at end of this cycle -> OUT.
//   - OUT: gnt_x=1, alu_en=1, done=1 -> IDLE; update rr_last to granted index.
// - alu_sel = latched opcode from LD_A through OUT; held at last value in IDLE.
// - Latency: request seen in IDLE -> done 4 cycles later (LD_A, LD_B, EXEC, OUT).
// - Minimum one IDLE cycle between transactions; back-to-back period 5 cycles.
// - Arbitration, evaluated in IDLE only:
//   - Single request wins.
//   - Both requests: grant the index != rr_last.
//   - op sampled only on the grant edge; later op/req changes ignored until done.
// - Requests dropped mid-transaction are ignored; the sequence completes.
// - Exactly one of gnt_0/gnt_1 is high at a time; alu_en is never high outside OUT.
//
// CONFIGURATION
// - DIV_ZERO_CHECK_EN defined:
//   - In EXEC, if latched op=11 and reg_b==0, go to OUT with alu_en=0, done=1, err=1; bus is left undriven.
// - DIV_ZERO_CHECK_EN undefined:
//   - reg_b is ignored and err is tied 0.
//   - DIV by zero executes normally; the result is whatever the ALU produces.
//
// TESTING
// - Reset: assert rst mid-EXEC -> all outputs 0 that cycle, state IDLE, no done; after release req_0 granted first.
// - Single op: req_0=1, op_0=00, bus A=5, B=3 -> load_a, load_b, EXEC, then OUT with alu_en=1, bus=8, done=1, gnt_0 high 4 cycles.
// - Contention: req_0 and req_1 both held high -> grants alternate 0,1,0,1; each done 5 cycles apart; never both gnt high.
// - Op latch: req_1 op_1=01, change op_1 to 10 during LD_B -> alu_sel stays 01; A=9, B=4 -> bus=5.
// - Div zero, macro on: op=11, B=0 -> done=1, err=1, alu_en=0 in OUT. Macro off: err=0, alu_en=1.
// - Drop request: deassert req_0 in LD_A -> sequence still completes with done; next IDLE grants a pending req_1.

Source files
------------

// File: rtl/alu_seq_arbiter_if.sv
// Handshake bundle between two ALU requesters and the alu_seq_arbiter sequencer.
// The slave modport is the arbiter view. The master modport is the requester/environment view.
interface alu_seq_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_0;
  logic [1:0]       op_0;
  logic             req_1;
  logic [1:0]       op_1;
  logic [WIDTH-1:0] reg_b;
  logic             gnt_0;
  logic             gnt_1;
  logic             load_a;
  logic             load_b;
  logic [1:0]       alu_sel;
  logic             alu_en;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output req_0, op_0, req_1, op_1, reg_b,
    input  gnt_0, gnt_1, load_a, load_b, alu_sel, alu_en, done, err, busy
  );

  modport slave (
    input  req_0, op_0, req_1, op_1, reg_b,
    output gnt_0, gnt_1, load_a, load_b, alu_sel, alu_en, done, err, busy
  );
endinterface

// File: rtl/alu_seq_arbiter.sv
// Round-robin owner of the shared 8-bit ALU: grant, load A, load B, execute, drive result.
// Optional macro DIV_ZERO_CHECK_EN aborts a DIV whose B register is zero (err pulse, no bus drive).
module alu_seq_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_seq_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, EXEC, OUT} state_t;

  state_t     state_q, state_d;
  logic       gnt_idx_q, gnt_idx_d;
  logic       rr_last_q, rr_last_d;
  logic       gnt_0_q, gnt_0_d;
  logic       gnt_1_q, gnt_1_d;
  logic       load_a_q, load_a_d;
  logic       load_b_q, load_b_d;
  logic [1:0] alu_sel_q, alu_sel_d;
  logic       alu_en_q, alu_en_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       owned;

  logic [WIDTH-1:0] div_b;
  assign div_b = bus.reg_b;

`ifndef DIV_ZERO_CHECK_EN
  logic unused_div_b;
  assign unused_div_b = ^div_b;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_last_d = rr_last_q;
    alu_sel_d = alu_sel_q;
    load_a_d  = 1'b0;
    load_b_d  = 1'b0;
    alu_en_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_0 || bus.req_1) begin
          // On a tie the requester that was not served last wins.
          gnt_idx_d = (bus.req_0 && bus.req_1) ? ~rr_last_q : bus.req_1;
          alu_sel_d = gnt_idx_d ? bus.op_1 : bus.op_0;
          load_a_d  = 1'b1;
          state_d   = LD_A;
        end
      end
      LD_A: begin
        load_b_d = 1'b1;
        state_d  = LD_B;
      end
      LD_B: state_d = EXEC;
      EXEC: begin
        done_d   = 1'b1;
        alu_en_d = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
        if (alu_sel_q == 2'b11 && div_b == '0) begin
          alu_en_d = 1'b0;
          err_d    = 1'b1;
        end
`endif
        state_d = OUT;
      end
      OUT: begin
        rr_last_d = gnt_idx_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Grant and busy follow ownership of the next state, so they stay registered.
    owned   = (state_d != IDLE);
    gnt_0_d = owned && !gnt_idx_d;
    gnt_1_d = owned && gnt_idx_d;
    busy_d  = owned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= 1'b0;
      rr_last_q <= 1'b1;
      gnt_0_q   <= 1'b0;
      gnt_1_q   <= 1'b0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      alu_sel_q <= 2'b00;
      alu_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_last_q <= rr_last_d;
      gnt_0_q   <= gnt_0_d;
      gnt_1_q   <= gnt_1_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      alu_sel_q <= alu_sel_d;
      alu_en_q  <= alu_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.gnt_0   = gnt_0_q;
  assign bus.gnt_1   = gnt_1_q;
  assign bus.load_a  = load_a_q;
  assign bus.load_b  = load_b_q;
  assign bus.alu_sel = alu_sel_q;
  assign bus.alu_en  = alu_en_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Scoreboard bench for alu_seq_arbiter: requesters, register file and ALU modelled around the DUT.
// A round-robin reference model queues expected transactions, and a monitor checks each done pulse.
module tb_alu_seq_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_arbiter_if #(.WIDTH(8)) bif ();

  alu_seq_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    bit       idx;
    bit [1:0] op;
    bit [7:0] res;
    bit       err;
    bit       en;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   model_rr = 1'b1;

  logic [7:0] opa [2];
  logic [7:0] opb [2];
  logic [7:0] reg_a_r = 8'h00;
  logic [7:0] reg_b_r = 8'h00;
  logic [7:0] alu_res_r = 8'h00;
  logic [7:0] data_bus;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [15:0] m;
    m = a * b;
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return m[7:0];
      default: return (b == 8'h00) ? 8'hFF : a / b;
    endcase
  endfunction

  // Shared bus: ALU result when enabled, otherwise the granted requester's operand.
  always_comb begin
    data_bus = 8'h00;
    if (bif.alu_en)      data_bus = alu_res_r;
    else if (bif.load_a) data_bus = bif.gnt_1 ? opa[1] : opa[0];
    else if (bif.load_b) data_bus = bif.gnt_1 ? opb[1] : opb[0];
  end

  always @(posedge clk) begin
    if (bif.load_a) reg_a_r <= data_bus;
    if (bif.load_b) reg_b_r <= data_bus;
    alu_res_r <= alu_f(reg_a_r, reg_b_r, bif.alu_sel);
  end
  assign bif.reg_b = reg_b_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every done pulse.
  int gnt_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        gnt_cnt = 0;
      end else begin
        if (bif.gnt_0 || bif.gnt_1) gnt_cnt++;
        else gnt_cnt = 0;
        check("one_gnt", {31'd0, bif.gnt_0 && bif.gnt_1}, 32'd0);
        check("alu_en_only_out", {31'd0, bif.alu_en && !bif.done}, 32'd0);
        check("busy_eq_gnt", {31'd0, bif.busy}, {31'd0, bif.gnt_0 || bif.gnt_1});
        if (gnt_cnt == 1) check("load_a_first", {31'd0, bif.load_a}, 32'd1);
        if (gnt_cnt == 2) check("load_b_second", {31'd0, bif.load_b}, 32'd1);
        if (bif.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("gnt_idx", {30'd0, bif.gnt_1, bif.gnt_0}, e.idx ? 32'd2 : 32'd1);
            check("alu_sel", {30'd0, bif.alu_sel}, {30'd0, e.op});
            check("err", {31'd0, bif.err}, {31'd0, e.err});
            check("alu_en", {31'd0, bif.alu_en}, {31'd0, e.en});
            check("latency", gnt_cnt, 32'd4);
            if (e.en) check("bus_result", {24'd0, data_bus}, {24'd0, e.res});
          end
        end
      end
    end
  end

  // Reference model: serve the pending set in round-robin order.
  task automatic model_round(input bit p0, input bit p1, input bit [1:0] op0, input bit [1:0] op1);
    bit   p [2];
    bit   w;
    exp_t e;
    p[0] = p0;
    p[1] = p1;
    while (p[0] || p[1]) begin
      if (p[0] && p[1]) w = !model_rr;
      else              w = p[1];
      e.idx = w;
      e.op  = w ? op1 : op0;
      e.res = alu_f(opa[w], opb[w], e.op);
`ifdef DIV_ZERO_CHECK_EN
      e.err = (e.op == 2'b11) && (opb[w] == 8'h00);
`else
      e.err = 1'b0;
`endif
      e.en  = !e.err;
      exp_q.push_back(e);
      p[w] = 1'b0;
      model_rr = w;
    end
  endtask

  task automatic run_round(input bit r0, input bit r1, input bit drop, input bit chg,
                           input bit fixed, input bit [1:0] fop, input bit [7:0] fa, input bit [7:0] fb);
    bit       pend [2];
    bit [1:0] op [2];
    int       cyc;
    for (int i = 0; i < 2; i++) begin
      if (fixed) begin
        op[i] = fop; opa[i] = fa; opb[i] = fb;
      end else begin
        op[i]  = 2'($urandom_range(0, 3));
        opa[i] = 8'($urandom);
        opb[i] = (op[i] == 2'b11 && $urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      end
    end
    pend[0] = r0;
    pend[1] = r1;
    model_round(r0, r1, op[0], op[1]);
    bif.op_0 = op[0]; bif.op_1 = op[1];
    bif.req_0 = r0;   bif.req_1 = r1;
    cyc = 0;
    while ((pend[0] || pend[1]) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bif.gnt_0 && bif.load_a && drop) bif.req_0 = 1'b0;
      if (bif.gnt_1 && bif.load_a && drop) bif.req_1 = 1'b0;
      if (bif.gnt_0 && bif.load_b && chg) bif.op_0 = ~bif.op_0;
      if (bif.gnt_1 && bif.load_b && chg) bif.op_1 = ~bif.op_1;
      if (bif.gnt_0 && bif.done) begin bif.req_0 = 1'b0; pend[0] = 1'b0; end
      if (bif.gnt_1 && bif.done) begin bif.req_1 = 1'b0; pend[1] = 1'b0; end
    end
    if (pend[0] || pend[1]) begin
      check("round_timeout", 32'd1, 32'd0);
      bif.req_0 = 1'b0;
      bif.req_1 = 1'b0;
    end
  endtask

  initial begin
    int k;
    bif.req_0 = 1'b0; bif.req_1 = 1'b0;
    bif.op_0 = 2'b00; bif.op_1 = 2'b00;
    opa[0] = 8'h00; opa[1] = 8'h00; opb[0] = 8'h00; opb[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {23'd0, bif.gnt_0, bif.gnt_1, bif.load_a, bif.load_b, bif.alu_sel,
                            bif.alu_en, bif.done, bif.err, bif.busy}, 32'd0);
    rst = 1'b0;

    // Abort in EXEC through asynchronous reset.
    @(negedge clk);
    bif.req_0 = 1'b1; bif.op_0 = 2'b10; opa[0] = 8'd3; opb[0] = 8'd4;
    k = 0;
    while (!bif.load_b && k < 10) begin @(negedge clk); k++; end
    check("reach_ld_b", {31'd0, bif.load_b}, 32'd1);
    @(negedge clk);
    check("exec_gnt", {31'd0, bif.gnt_0}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {23'd0, bif.gnt_0, bif.gnt_1, bif.load_a, bif.load_b, bif.alu_sel,
                                  bif.alu_en, bif.done, bif.err, bif.busy}, 32'd0);
    bif.req_0 = 1'b0;
    @(negedge clk);
    check("no_done_in_reset", {31'd0, bif.done}, 32'd0);
    rst = 1'b0;
    model_rr = 1'b1;

    // After reset a tie goes to requester 0 first.
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'd10, 8'd20);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd5, 8'd3);
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 8'd9, 8'd4);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'd7, 8'd0);
    run_round(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) run_round(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(1, 3);
      run_round(k[0], k[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b0, 2'b00, 8'd0, 8'd0);
    end

    repeat (8) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
